// File: rtl/ddr_cmd_arbiter.sv
// Arbitrates the read and write request queues onto one DDR controller app port.
// Each read is one command; each write pushes two 64-bit data beats and then its command.
module ddr_cmd_arbiter #(
  parameter int unsigned MAX_STREAK = 4,
  parameter logic [2:0]  RD_CMD     = 3'b001,
  parameter logic [2:0]  WR_CMD     = 3'b000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         init_calib_complete_i,
  input  logic         rd_has_req_i,
  input  logic [26:0]  rd_adx_i,
  output logic         rd_get_o,
  input  logic         wr_has_req_i,
  input  logic [26:0]  wr_adx_i,
  input  logic [127:0] wr_data_i,
  output logic         wr_get_o,
  input  logic         app_rdy_i,
  output logic         app_en_o,
  output logic [2:0]   app_cmd_o,
  output logic [26:0]  app_addr_o,
  input  logic         app_wdf_rdy_i,
  output logic         app_wdf_wren_o,
  output logic [63:0]  app_wdf_data_o,
  output logic         app_wdf_end_o,
  output logic         busy_o,
  output logic [31:0]  rd_issued_o,
  output logic [31:0]  wr_issued_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RD,
    LOAD_WR,
    RD_ISSUE,
    WR_BEAT1,
    WR_BEAT2,
    WR_ISSUE
  } state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);
  localparam logic [3:0] STREAK_SAT   = 4'd15;

  state_t        state_q, state_d;
  logic          last_wr_q, last_wr_d;
  logic [3:0]    streak_q, streak_d;
  logic [26:0]   adx_q, adx_d;
  logic [127:0]  data_q, data_d;
  logic [31:0]   rd_cnt_q, rd_cnt_d;
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic          grant_wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      streak_q  <= 4'd0;
      adx_q     <= 27'd0;
      data_q    <= 128'd0;
      rd_cnt_q  <= 32'd0;
      wr_cnt_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      streak_q  <= streak_d;
      adx_q     <= adx_d;
      data_q    <= data_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_wr_d      = last_wr_q;
    streak_d       = streak_q;
    adx_d          = adx_q;
    data_d         = data_q;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    grant_wr       = 1'b0;
    rd_get_o       = 1'b0;
    wr_get_o       = 1'b0;
    app_en_o       = 1'b0;
    app_cmd_o      = 3'd0;
    app_addr_o     = 27'd0;
    app_wdf_wren_o = 1'b0;
    app_wdf_data_o = 64'd0;
    app_wdf_end_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_calib_complete_i && (rd_has_req_i || wr_has_req_i)) begin
          // Contention: stay with the last type until its streak reaches the limit.
          if (rd_has_req_i && wr_has_req_i) begin
            grant_wr = (streak_q < STREAK_LIMIT) ? last_wr_q : ~last_wr_q;
          end else begin
            grant_wr = wr_has_req_i;
          end

          if (grant_wr) begin
            wr_get_o = 1'b1;
            state_d  = LOAD_WR;
          end else begin
            rd_get_o = 1'b1;
            state_d  = LOAD_RD;
          end

          if (grant_wr == last_wr_q) begin
            streak_d = (streak_q == STREAK_SAT) ? STREAK_SAT : streak_q + 4'd1;
          end else begin
            last_wr_d = grant_wr;
            streak_d  = 4'd1;
          end
        end
      end

      LOAD_RD: begin
        adx_d   = rd_adx_i;
        state_d = RD_ISSUE;
      end

      LOAD_WR: begin
        adx_d   = wr_adx_i;
        data_d  = wr_data_i;
        state_d = WR_BEAT1;
      end

      RD_ISSUE: begin
        app_en_o   = 1'b1;
        app_cmd_o  = RD_CMD;
        app_addr_o = adx_q;
        if (app_rdy_i) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
          state_d  = IDLE;
        end
      end

      WR_BEAT1: begin
        app_wdf_wren_o = 1'b1;
        app_wdf_data_o = data_q[63:0];
        if (app_wdf_rdy_i) begin
          state_d = WR_BEAT2;
        end
      end

      WR_BEAT2: begin
        app_wdf_wren_o = 1'b1;
        app_wdf_data_o = data_q[127:64];
        app_wdf_end_o  = 1'b1;
        if (app_wdf_rdy_i) begin
          state_d = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        app_en_o   = 1'b1;
        app_cmd_o  = WR_CMD;
        app_addr_o = adx_q;
        if (app_rdy_i) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign rd_issued_o = rd_cnt_q;
  assign wr_issued_o = wr_cnt_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: queue-based source model, transaction scoreboard and directed scenarios.
module tb_ddr_cmd_arbiter;

  localparam int MAX_STREAK = 4;
  localparam logic [2:0] RD_CMD = 3'b001;
  localparam logic [2:0] WR_CMD = 3'b000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, init_calib_complete;
  logic         rd_has_req, wr_has_req, app_rdy, app_wdf_rdy;
  logic [26:0]  rd_adx, wr_adx;
  logic [127:0] wr_data;
  logic         rd_get, wr_get, app_en, app_wdf_wren, app_wdf_end, busy;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic [63:0]  app_wdf_data;
  logic [31:0]  rd_issued, wr_issued;

  ddr_cmd_arbiter #(.MAX_STREAK(MAX_STREAK), .RD_CMD(RD_CMD), .WR_CMD(WR_CMD)) dut (
    .clk(clk), .resetn(resetn), .init_calib_complete_i(init_calib_complete),
    .rd_has_req_i(rd_has_req), .rd_adx_i(rd_adx), .rd_get_o(rd_get),
    .wr_has_req_i(wr_has_req), .wr_adx_i(wr_adx), .wr_data_i(wr_data), .wr_get_o(wr_get),
    .app_rdy_i(app_rdy), .app_en_o(app_en), .app_cmd_o(app_cmd), .app_addr_o(app_addr),
    .app_wdf_rdy_i(app_wdf_rdy), .app_wdf_wren_o(app_wdf_wren), .app_wdf_data_o(app_wdf_data),
    .app_wdf_end_o(app_wdf_end), .busy_o(busy), .rd_issued_o(rd_issued), .wr_issued_o(wr_issued)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Source queues: contents owned by the bench, popped by the scoreboard on each grant.
  logic [26:0]  rdq[$];
  logic [26:0]  wrq_a[$];
  logic [127:0] wrq_d[$];
  logic [26:0]  stg_rd_adx = '0;
  logic [26:0]  stg_wr_adx = '0;
  logic [127:0] stg_wr_dat = '0;

  initial begin
    rd_adx = '0; wr_adx = '0; wr_data = '0; rd_has_req = 1'b0; wr_has_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_adx  = stg_rd_adx;
      wr_adx  = stg_wr_adx;
      wr_data = stg_wr_dat;
      #1;
      rd_has_req = (rdq.size() != 0);
      wr_has_req = (wrq_a.size() != 0);
    end
  end

  // Transaction-level model: arbitration history, outstanding transaction, expected handshakes.
  bit          m_last_wr = 1'b0;
  int          m_streak  = 0;
  bit          m_inflight = 1'b0;
  logic [31:0] m_rd_cnt = '0;
  logic [31:0] m_wr_cnt = '0;
  bit          ev_kind[$];
  logic [63:0] ev_val[$];
  logic [2:0]  ev_aux[$];
  bit          hold_cmd = 1'b0, hold_beat = 1'b0;
  logic [2:0]  prev_cmd;
  logic [26:0] prev_addr;
  logic [63:0] prev_dat;
  logic        prev_end;

  initial begin
    bit exp_grant, g_wr, ok;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_last_wr = 1'b0; m_streak = 0; m_inflight = 1'b0;
        m_rd_cnt = '0; m_wr_cnt = '0;
        ev_kind.delete(); ev_val.delete(); ev_aux.delete();
        rdq.delete(); wrq_a.delete(); wrq_d.delete();
        hold_cmd = 1'b0; hold_beat = 1'b0;
      end else begin
        chk("m_busy", busy, m_inflight);
        chk("m_rd_issued", rd_issued, m_rd_cnt);
        chk("m_wr_issued", wr_issued, m_wr_cnt);
        chk("m_en_wren_exclusive", app_en & app_wdf_wren, 1'b0);
        exp_grant = !m_inflight && init_calib_complete && (rd_has_req || wr_has_req);
        if (exp_grant) begin
          if (rd_has_req && wr_has_req) g_wr = (m_streak < MAX_STREAK) ? m_last_wr : !m_last_wr;
          else g_wr = wr_has_req;
          chk("m_grant_rd", rd_get, !g_wr);
          chk("m_grant_wr", wr_get, g_wr);
          if (g_wr == m_last_wr) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
          else begin m_last_wr = g_wr; m_streak = 1; end
          m_inflight = 1'b1;
          if (g_wr && wrq_a.size() != 0) begin
            stg_wr_adx = wrq_a.pop_front();
            stg_wr_dat = wrq_d.pop_front();
            ev_kind.push_back(1'b0); ev_val.push_back(stg_wr_dat[63:0]);   ev_aux.push_back(3'd0);
            ev_kind.push_back(1'b0); ev_val.push_back(stg_wr_dat[127:64]); ev_aux.push_back(3'd1);
            ev_kind.push_back(1'b1); ev_val.push_back({37'd0, stg_wr_adx}); ev_aux.push_back(WR_CMD);
          end else if (!g_wr && rdq.size() != 0) begin
            stg_rd_adx = rdq.pop_front();
            ev_kind.push_back(1'b1); ev_val.push_back({37'd0, stg_rd_adx}); ev_aux.push_back(RD_CMD);
          end
        end else begin
          chk("m_no_rd_get", rd_get, 1'b0);
          chk("m_no_wr_get", wr_get, 1'b0);
        end
        if (hold_cmd) begin
          chk("m_hold_en", app_en, 1'b1);
          chk("m_hold_cmd", app_cmd, prev_cmd);
          chk("m_hold_addr", app_addr, prev_addr);
        end
        if (hold_beat) begin
          chk("m_hold_wren", app_wdf_wren, 1'b1);
          chk("m_hold_data", app_wdf_data, prev_dat);
          chk("m_hold_end", app_wdf_end, prev_end);
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          ok = (ev_kind.size() != 0) && (ev_kind[0] == 1'b0);
          chk("m_beat_order", ok, 1'b1);
          if (ok) begin
            chk("m_beat_data", app_wdf_data, ev_val[0]);
            chk("m_beat_end", app_wdf_end, ev_aux[0][0]);
            void'(ev_kind.pop_front()); void'(ev_val.pop_front()); void'(ev_aux.pop_front());
          end
        end
        if (app_en && app_rdy) begin
          ok = (ev_kind.size() != 0) && (ev_kind[0] == 1'b1);
          chk("m_cmd_order", ok, 1'b1);
          if (ok) begin
            chk("m_cmd_code", app_cmd, ev_aux[0]);
            chk("m_cmd_addr", app_addr, ev_val[0][26:0]);
            if (ev_aux[0] == RD_CMD) m_rd_cnt = m_rd_cnt + 32'd1;
            else m_wr_cnt = m_wr_cnt + 32'd1;
            void'(ev_kind.pop_front()); void'(ev_val.pop_front()); void'(ev_aux.pop_front());
          end
          m_inflight = 1'b0;
        end
        hold_cmd  = app_en && !app_rdy;
        hold_beat = app_wdf_wren && !app_wdf_rdy;
        prev_cmd = app_cmd; prev_addr = app_addr; prev_dat = app_wdf_data; prev_end = app_wdf_end;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_get(input bit want_wr, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = want_wr ? wr_get : rd_get;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !rd_get && !wr_get && !rd_has_req && !wr_has_req
             && rdq.size() == 0 && wrq_a.size() == 0;
    end
    chk("drain_idle", idle, 1'b1);
  endtask

  bit exp_seq [9];
  bit got_seq [9];

  initial begin
    int ng;
    resetn = 1'b0; init_calib_complete = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_cmd", app_cmd, 3'd0);
    chk("rst_addr", app_addr, 27'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_issued", rd_issued, 32'd0);
    chk("rst_wr_issued", wr_issued, 32'd0);

    // Calibration gate, then one read followed by one write.
    step();
    resetn = 1'b1;
    rdq.push_back(27'h0ABCDEF);
    wrq_a.push_back(27'h100);
    wrq_d.push_back(128'h1111111111111111_2222222222222222);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("gate_rd_get", rd_get, 1'b0);
      chk("gate_wr_get", wr_get, 1'b0);
      chk("gate_app_en", app_en, 1'b0);
      chk("gate_busy", busy, 1'b0);
    end
    step();
    init_calib_complete = 1'b1;
    @(negedge clk);
    chk("open_rd_get", rd_get, 1'b1);
    chk("open_wr_get", wr_get, 1'b0);
    @(negedge clk);
    chk("rd_load_en", app_en, 1'b0);
    chk("rd_load_busy", busy, 1'b1);
    @(negedge clk);
    chk("rd_issue_en", app_en, 1'b1);
    chk("rd_issue_cmd", app_cmd, 3'b001);
    chk("rd_issue_addr", app_addr, 27'h0ABCDEF);
    @(negedge clk);
    chk("rd_done_en", app_en, 1'b0);
    chk("rd_done_cnt", rd_issued, 32'd1);
    chk("wr_grant", wr_get, 1'b1);
    @(negedge clk);
    chk("wr_load_wren", app_wdf_wren, 1'b0);
    @(negedge clk);
    chk("wr_b1_wren", app_wdf_wren, 1'b1);
    chk("wr_b1_data", app_wdf_data, 64'h2222222222222222);
    chk("wr_b1_end", app_wdf_end, 1'b0);
    chk("wr_b1_en", app_en, 1'b0);
    @(negedge clk);
    chk("wr_b2_data", app_wdf_data, 64'h1111111111111111);
    chk("wr_b2_end", app_wdf_end, 1'b1);
    @(negedge clk);
    chk("wr_issue_en", app_en, 1'b1);
    chk("wr_issue_cmd", app_cmd, 3'b000);
    chk("wr_issue_addr", app_addr, 27'h100);
    chk("wr_issue_wren", app_wdf_wren, 1'b0);
    @(negedge clk);
    chk("wr_done_cnt", wr_issued, 32'd1);
    chk("wr_done_busy", busy, 1'b0);

    // Arbitration under constant contention, from a fresh reset.
    step(); resetn = 1'b0;
    step(); resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdq.push_back(27'h10 + 27'(i));
      wrq_a.push_back(27'h20 + 27'(i));
      wrq_d.push_back({64'hC0DE_0000_0000_0000 + 64'(i), 64'hBEEF_0000_0000_0000 + 64'(i)});
    end
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ng = 0;
    for (int c = 0; c < 300 && ng < 9; c++) begin
      @(negedge clk);
      if (rd_get || wr_get) begin
        got_seq[ng] = wr_get;
        ng++;
      end
    end
    chk("arb_grant_count", ng, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("arb_grant_%0d_is_wr", i), got_seq[i], exp_seq[i]);
    drain();
    chk("arb_rd_total", rd_issued, 32'd5);
    chk("arb_wr_total", wr_issued, 32'd5);

    // Read command held under app_rdy backpressure.
    step();
    app_rdy = 1'b0;
    rdq.push_back(27'h7654321);
    wait_get(1'b0, "bp_rd_get_seen");
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_rd_en_held", app_en, 1'b1);
      chk("bp_rd_addr_held", app_addr, 27'h7654321);
    end
    step();
    app_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rd_en_8th", app_en, 1'b1);
    chk("bp_rd_cnt_before", rd_issued, 32'd5);
    @(negedge clk);
    chk("bp_rd_en_released", app_en, 1'b0);
    chk("bp_rd_cnt_after", rd_issued, 32'd6);

    // Second write beat held under app_wdf_rdy backpressure.
    wrq_a.push_back(27'h3);
    wrq_d.push_back({64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
    wait_get(1'b1, "bp_wr_get_seen");
    @(negedge clk);
    @(negedge clk);
    chk("bp_wr_b1_data", app_wdf_data, 64'h5555_5555_5555_5555);
    step();
    app_wdf_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_wr_b2_wren", app_wdf_wren, 1'b1);
      chk("bp_wr_b2_data", app_wdf_data, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("bp_wr_b2_end", app_wdf_end, 1'b1);
      chk("bp_wr_no_cmd", app_en, 1'b0);
    end
    step();
    app_wdf_rdy = 1'b1;
    @(negedge clk);
    chk("bp_wr_b2_accept", app_wdf_wren, 1'b1);
    @(negedge clk);
    chk("bp_wr_issue_en", app_en, 1'b1);
    chk("bp_wr_issue_addr", app_addr, 27'h3);
    @(negedge clk);
    chk("bp_wr_cnt", wr_issued, 32'd6);

    // Reset landing in the middle of a write.
    step();
    app_wdf_rdy = 1'b0;
    wrq_a.push_back(27'h55);
    wrq_d.push_back({64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321});
    wait_get(1'b1, "rst_wr_get_seen");
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_b1_wren", app_wdf_wren, 1'b1);
    step();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_wren", app_wdf_wren, 1'b0);
    chk("rst_mid_data", app_wdf_data, 64'd0);
    chk("rst_mid_end", app_wdf_end, 1'b0);
    chk("rst_mid_en", app_en, 1'b0);
    chk("rst_mid_addr", app_addr, 27'd0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rd_cnt", rd_issued, 32'd0);
    chk("rst_mid_wr_cnt", wr_issued, 32'd0);
    step();
    resetn = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_mid_dropped_idle", busy, 1'b0);
      chk("rst_mid_dropped_no_en", app_en, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Shares the single DDR memory-controller app interface between the read request queue and the write request queue.
- Pops the next command from whichever queue wins arbitration.
- For reads, issues the read command; the read-data path separately captures the returned two-beat data.
- For writes, pushes two 64-bit data beats, then issues the write command.

Parameters:
- MAX_STREAK, 4: max consecutive grants to one type while the other type is waiting (1..15).
- RD_CMD, 3'b001: app_cmd encoding for read.
- WR_CMD, 3'b000: app_cmd encoding for write.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- init_calib_complete  in  1  controller calibrated; no grants while low.
- rd_has_req  in  1  read address queue non-empty.
- rd_adx  in  27  read queue dout; valid the cycle after rd_get.
- rd_get  out  1  one-cycle pop strobe to read queue.
- wr_has_req  in  1  write queue non-empty.
- wr_adx  in  27  write queue address dout; valid the cycle after wr_get.
- wr_data  in  128  write queue data dout; valid the cycle after wr_get.
- wr_get  out  1  one-cycle pop strobe to write queue.
- app_rdy  in  1  controller accepts command.
- app_en  out  1  command valid.
- app_cmd  out  3  command code.
- app_addr  out  27  command address.
- app_wdf_rdy  in  1  controller accepts write data beat.
- app_wdf_wren  out  1  write data beat valid.
- app_wdf_data  out  64  write data beat.
- app_wdf_end  out  1  last beat of burst.
- busy  out  1  state != IDLE.
- rd_issued  out  32  reads accepted by controller, wraps.
- wr_issued  out  32  writes accepted by controller, wraps.

Behaviour:
- Reset values: all outputs 0; app_cmd = 0; state IDLE; last_type = READ; streak = 0; latched adx/data regs = 0.
- Reset mid-operation: reset aborts immediately and any popped entry is dropped. Source queues share the reset.
- States: IDLE, LOAD_RD, LOAD_WR, RD_ISSUE, WR_BEAT1, WR_BEAT2, WR_ISSUE.
- IDLE: grant only when init_calib_complete = 1 and at least one *_has_req is set.
  - Only one type pending: grant it.
  - Both pending: grant last_type if streak < MAX_STREAK, else the other type.
  - On grant, assert rd_get or wr_get combinationally for exactly that cycle, then go to LOAD_RD or LOAD_WR.
  - Granting the same type as last_type: streak = min(streak+1, 15). Otherwise last_type = granted type and streak = 1.
- LOAD_RD: latch rd_adx, go to RD_ISSUE.
- LOAD_WR: latch wr_adx and wr_data, go to WR_BEAT1.
- RD_ISSUE: app_en = 1, app_cmd = RD_CMD, app_addr = latched adx, held until app_rdy = 1. On that cycle, rd_issued += 1 and go to IDLE.
- WR_BEAT1: app_wdf_wren = 1, app_wdf_data = data[63:0], app_wdf_end = 0, held until app_wdf_rdy = 1; then go to WR_BEAT2.
- WR_BEAT2: app_wdf_wren = 1, app_wdf_data = data[127:64], app_wdf_end = 1, held until app_wdf_rdy = 1; then go to WR_ISSUE.
- WR_ISSUE: app_en = 1, app_cmd = WR_CMD, app_addr = latched adx, held until app_rdy = 1. On that cycle, wr_issued += 1 and go to IDLE.
- app_en and app_wdf_wren are never asserted in the same cycle. At most one *_get per grant; never both.
- While app_en or app_wdf_wren is held waiting for rdy, addr, cmd and data stay stable.
- Throughput with rdy always high:
  - Read: 3 cycles per read (IDLE, LOAD, ISSUE).
  - Write: 5 cycles per write.
- init_calib_complete dropping mid-transaction does not abort; it only blocks the next grant.
- Counters wrap 0xFFFFFFFF -> 0.
- A has_req deasserted in the same cycle as the grant is a source-protocol violation; behaviour is undefined.

Test Plan:
- Calibration gate: init_calib_complete = 0 with both has_req = 1 for 20 cycles -> no *_get, app_en = 0, busy = 0. Raise it -> rd_get pulses in the next cycle.
- Single read: rd_adx = 27'h0ABCDEF, app_rdy = 1 -> rd_get 1 cycle; 2 cycles later app_en = 1, app_cmd = 001, app_addr = 0ABCDEF for 1 cycle; rd_issued = 1.
- Single write: wr_data = 128'h1111..._2222..., wr_adx = 27'h100, all rdy high -> beat 64'h2222... with end = 0, then beat 64'h1111... with end = 1, then app_en with cmd = 000 and addr = 100; wr_issued = 1.
- Arbitration: MAX_STREAK = 4, both queues always pending -> grant order R,R,R,R,W,W,W,W,R.
- Backpressure: app_rdy = 0 for 7 cycles during RD_ISSUE -> app_en/addr held for 8 cycles, counter increments once. app_wdf_rdy = 0 during WR_BEAT2 -> data and end held, no command issued before the beat is accepted.
- Reset mid-write: resetn = 0 during WR_BEAT1 -> next cycle all outputs 0, state IDLE, counters 0.
